ahb_lite_fir_master: RTL and testbench

//  AHB-Lite bus master that sits directly upstream of ahb_lite_fir_filter and drives its slave port.

---
 rtl/ahb_lite_fir_master.sv | 228 ++++++++++++++++++++++
 tb/tb_ahb_lite_fir_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_fir_master.sv
// ahb_lite_fir_master
//   AHB-Lite master that feeds samples to an ahb_lite_fir_filter slave. Each
//   sample goes into a small FIFO. For every sample, the master writes the
//   sample register, polls the status register until the filter is idle, and
//   then reads the result register. The result and its error flags come back
//   on a one-cycle strobe.
//
// Ports
//   clk, n_rst        clock (rising edge), asynchronous active-low reset
//   sample_in/valid   incoming sample; accepted when sample_valid & sample_ready
//   sample_ready      FIFO not full
//   result_out        filtered result (0 on error)
//   result_valid      one-cycle strobe qualifying result_out/result_err/fir_err
//   result_err        bus error or poll timeout for this sample
//   fir_err           status err bit seen on the final (idle) poll
//   hsel/haddr/hsize/htrans/hwrite/hwdata   AHB-Lite master outputs
//   hrdata/hresp      AHB-Lite slave responses (zero-wait slave)
module ahb_lite_fir_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_DLY   = 2,
    parameter int MAX_POLLS  = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] result_out,
    output logic        result_valid,
    output logic        result_err,
    output logic        fir_err,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int DW = $clog2(POLL_DLY + 2);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'((POLL_DLY > 0) ? (POLL_DLY - 1) : 0);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_D, S_WAIT, S_PL_A,
        S_PL_D, S_RD_A, S_RD_D, S_DONE, S_ERR
    } state_t;

    state_t          state;
    logic [15:0]     cur;
    logic [PW-1:0]   poll_cnt;
    logic [DW-1:0]   dly_cnt;
    logic            fir_flag;

    // ---------------- sample FIFO ----------------
    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            push;
    logic            pop;

    assign push  = sample_valid && sample_ready;
    assign pop   = (state == S_IDLE) && (count != '0);
    assign hsize = 1'b1;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= sample_in;
    end

    // sample_ready is registered from the next fill level so it is exactly
    // "not full" in every cycle, and stays low while n_rst is asserted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sample_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count        <= count_next;
            sample_ready <= (count_next != FIFO_FULL);
        end
    end

    // ---------------- transaction FSM ----------------
    // Bus and result outputs are registered. Each transition loads the
    // values that belong to the state being entered, so outputs line up
    // with the state in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= S_IDLE;
            cur          <= '0;
            poll_cnt     <= '0;
            dly_cnt      <= '0;
            fir_flag     <= 1'b0;
            hsel         <= 1'b0;
            haddr        <= '0;
            htrans       <= HT_IDLE;
            hwrite       <= 1'b0;
            hwdata       <= '0;
            result_out   <= '0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
            fir_err      <= 1'b0;
        end else begin
            hsel         <= 1'b0;
            haddr        <= '0;
            htrans       <= HT_IDLE;
            hwrite       <= 1'b0;
            hwdata       <= '0;
            result_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state  <= S_WR_A;
                        cur    <= fifo_mem[rd_ptr];
                        hsel   <= 1'b1;
                        htrans <= HT_NONSEQ;
                        haddr  <= 4'h4;
                        hwrite <= 1'b1;
                    end
                end
                S_WR_A: begin
                    state  <= S_WR_D;
                    hwdata <= cur;
                end
                S_WR_D: begin
                    if (hresp) begin
                        state        <= S_ERR;
                        result_valid <= 1'b1;
                        result_err   <= 1'b1;
                        result_out   <= '0;
                        fir_err      <= 1'b0;
                    end else if (POLL_DLY == 0) begin
                        state    <= S_PL_A;
                        poll_cnt <= '0;
                        hsel     <= 1'b1;
                        htrans   <= HT_NONSEQ;
                    end else begin
                        state   <= S_WAIT;
                        dly_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (dly_cnt == DLY_LAST) begin
                        state    <= S_PL_A;
                        poll_cnt <= '0;
                        hsel     <= 1'b1;
                        htrans   <= HT_NONSEQ;
                    end else begin
                        dly_cnt <= dly_cnt + DW'(1);
                    end
                end
                S_PL_A: begin
                    state <= S_PL_D;
                end
                S_PL_D: begin
                    // poll_cnt counts polls already completed before this one,
                    // so POLL_LAST here means this was poll number MAX_POLLS.
                    if (hresp || (hrdata[0] && poll_cnt == POLL_LAST)) begin
                        state        <= S_ERR;
                        result_valid <= 1'b1;
                        result_err   <= 1'b1;
                        result_out   <= '0;
                        fir_err      <= 1'b0;
                    end else if (hrdata[0]) begin
                        state    <= S_PL_A;
                        poll_cnt <= poll_cnt + PW'(1);
                        hsel     <= 1'b1;
                        htrans   <= HT_NONSEQ;
                    end else begin
                        state    <= S_RD_A;
                        fir_flag <= hrdata[8];
                        hsel     <= 1'b1;
                        htrans   <= HT_NONSEQ;
                        haddr    <= 4'h2;
                    end
                end
                S_RD_A: begin
                    state <= S_RD_D;
                end
                S_RD_D: begin
                    if (hresp) begin
                        state        <= S_ERR;
                        result_valid <= 1'b1;
                        result_err   <= 1'b1;
                        result_out   <= '0;
                        fir_err      <= 1'b0;
                    end else begin
                        state        <= S_DONE;
                        result_valid <= 1'b1;
                        result_err   <= 1'b0;
                        result_out   <= hrdata;
                        fir_err      <= fir_flag;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_fir_master.sv
// Testbench for ahb_lite_fir_master. A stub filter slave answers the bus.
// Expected results are queued when samples are pushed and are compared when
// the DUT strobes result_valid. The bench also logs address phases and checks
// them against the expected write/poll/read sequence.
module tb_ahb_lite_fir_master;

    typedef struct packed {
        logic [15:0] out;
        logic        err;
        logic        fir;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] result_out;
    logic        result_valid;
    logic        result_err;
    logic        fir_err;
    logic        hsel;
    logic [3:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_strobe = 0;
    int strobe_cyc = 0;
    int last_acc = 0;
    int last_wait = 0;

    exp_t        sb[$];
    logic [15:0] wr_q[$];
    logic [4:0]  bus_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ahb_lite_fir_master #(
        .FIFO_DEPTH(4),
        .POLL_DLY  (2),
        .MAX_POLLS (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .result_out  (result_out),
        .result_valid(result_valid),
        .result_err  (result_err),
        .fir_err     (fir_err),
        .hsel        (hsel),
        .haddr       (haddr),
        .hsize       (hsize),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hresp       (hresp)
    );

    // ---------------- stub filter slave ----------------
    int          busy_cfg = 0;     // polls reporting busy after each write
    logic        stat_err = 1'b0;  // status bit8
    int          fail_write = -1;  // index of the write that gets hresp
    int          write_cnt = 0;
    int          poll_idx = 0;
    logic [15:0] res_reg = '0;
    logic        dp_valid = 1'b0;
    logic [3:0]  dp_addr = '0;
    logic        dp_write = 1'b0;

    always @(posedge clk) begin
        if (!n_rst) begin
            dp_valid <= 1'b0;
        end else begin
            if (dp_valid && dp_write) begin
                write_cnt <= write_cnt + 1;
                poll_idx  <= 0;
                if (write_cnt != fail_write)
                    res_reg <= hwdata + 16'h1234;
            end else if (dp_valid && dp_addr == 4'h0) begin
                poll_idx <= poll_idx + 1;
            end
            dp_valid <= (htrans == 2'b10);
            dp_addr  <= haddr;
            dp_write <= hwrite;
        end
    end

    always_comb begin
        hrdata = '0;
        hresp  = 1'b0;
        if (dp_valid) begin
            if (dp_write)
                hresp = (write_cnt == fail_write);
            else if (dp_addr == 4'h0)
                hrdata = {7'b0, stat_err, 7'b0, (poll_idx < busy_cfg)};
            else if (dp_addr == 4'h2)
                hrdata = res_reg;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] o, input logic e, input logic f);
        exp_t r;
        r.out = o;
        r.err = e;
        r.fir = f;
        return r;
    endfunction

    function automatic exp_t ok(input logic [15:0] d);
        return mk(d + 16'h1234, 1'b0, 1'b0);
    endfunction

    function automatic logic [4:0] pop_log();
        if (bus_log.size() == 0)
            return 5'h1F;
        return bus_log.pop_front();
    endfunction

    // Address-phase sequence of one sample: write @4, polls @0, optional read @2.
    task automatic expect_seq(input string tag, input int polls, input bit rd);
        check({tag, "_wr"}, 32'(pop_log()), 32'h9);
        for (int i = 0; i < polls; i++)
            check({tag, "_poll"}, 32'(pop_log()), 32'h0);
        if (rd)
            check({tag, "_rd"}, 32'(pop_log()), 32'h4);
    endtask

    // ---------------- monitor ----------------
    logic wr_dp = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        check("hsel", 32'(hsel), 32'(htrans != 2'b00));
        check("hsize", 32'(hsize), 32'd1);
        check("htrans_legal", 32'(htrans == 2'b00 || htrans == 2'b10), 32'd1);
        if (wr_dp) begin
            check("wr_q_nonempty", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0)
                check("hwdata", 32'(hwdata), 32'(wr_q.pop_front()));
        end else begin
            check("hwdata_idle", 32'(hwdata), 32'd0);
        end
        wr_dp = (htrans == 2'b10) && hwrite;
        if (htrans == 2'b10)
            bus_log.push_back({haddr, hwrite});
        if (result_valid) begin
            n_strobe++;
            strobe_cyc = cyc;
            $display("result @%0d: out=0x%04h err=%0b fir_err=%0b", cyc, result_out, result_err, fir_err);
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("result_out", 32'(result_out), 32'(e.out));
                check("result_err", 32'(result_err), 32'(e.err));
                check("fir_err", 32'(fir_err), 32'(e.fir));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [15:0] d, input exp_t e);
        int t = 0;
        while (sample_ready !== 1'b1 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        last_wait = t;
        check("push_ready", 32'(sample_ready), 32'd1);
        sample_in    = d;
        sample_valid = 1'b1;
        sb.push_back(e);
        wr_q.push_back(d);
        @(posedge clk);
        #1;
        last_acc     = cyc;
        sample_valid = 1'b0;
        sample_in    = '0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 600) begin
            @(posedge clk);
            t++;
        end
        #1;
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int found;
        int n0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", 32'(haddr), 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_result_out", 32'(result_out), 32'd0);
        check("rst_sample_ready", 32'(sample_ready), 32'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(sample_ready), 32'd1);

        // 1: single sample, filter idle at once, latency k+9
        push(16'h0100, ok(16'h0100));
        drain("t1");
        check("t1_latency", 32'(strobe_cyc - last_acc), 32'd9);
        expect_seq("t1", 1, 1'b1);

        // 2: busy for 3 polls -> 4 polls
        busy_cfg = 3;
        push(16'h0200, ok(16'h0200));
        drain("t2");
        expect_seq("t2", 4, 1'b1);

        // 3: busy stuck -> timeout after exactly 4 polls, next sample fine
        busy_cfg = 1000;
        push(16'h0300, mk(16'h0000, 1'b1, 1'b0));
        drain("t3a");
        expect_seq("t3a", 4, 1'b0);
        busy_cfg = 0;
        push(16'h0301, ok(16'h0301));
        drain("t3b");
        expect_seq("t3b", 1, 1'b1);

        // 4: hresp on A's write -> ERR, B proceeds
        fail_write = write_cnt;
        push(16'h0400, mk(16'h0000, 1'b1, 1'b0));
        push(16'h0401, ok(16'h0401));
        drain("t4");
        expect_seq("t4a", 0, 1'b0);
        expect_seq("t4b", 1, 1'b1);
        fail_write = -1;

        // 5: leader in flight, 4 pushes fill the FIFO, 5th is held
        busy_cfg = 2;
        push(16'h0500, ok(16'h0500));
        for (int i = 1; i <= 4; i++)
            push(16'h0500 + 16'(i), ok(16'h0500 + 16'(i)));
        check("t5_ready_full", 32'(sample_ready), 32'd0);
        push(16'h0505, ok(16'h0505));
        check("t5_held", 32'(last_wait > 0), 32'd1);
        drain("t5");
        for (int i = 0; i < 6; i++)
            expect_seq("t5", 3, 1'b1);

        // 6a: status err bit on the idle poll -> fir_err with a valid result
        busy_cfg = 0;
        stat_err = 1'b1;
        push(16'h0600, mk(16'h1834, 1'b0, 1'b1));
        drain("t6a");
        expect_seq("t6a", 1, 1'b1);
        stat_err = 1'b0;

        // 6b: reset during PL_D abandons the sequence and flushes the FIFO
        busy_cfg = 2;
        push(16'h0700, ok(16'h0700));
        push(16'h0701, ok(16'h0701));
        push(16'h0702, ok(16'h0702));
        found = 0;
        for (int t = 0; t < 60 && found == 0; t++) begin
            if (htrans == 2'b10 && haddr == 4'h0 && !hwrite)
                found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("t6b_found_pl_a", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("t6b_rst_htrans", 32'(htrans), 32'd0);
        check("t6b_rst_hsel", 32'(hsel), 32'd0);
        check("t6b_rst_valid", 32'(result_valid), 32'd0);
        check("t6b_rst_ready", 32'(sample_ready), 32'd0);
        sb.delete();
        wr_q.delete();
        bus_log.delete();
        busy_cfg = 0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        n0 = n_strobe;
        repeat (20) @(posedge clk);
        #1;
        check("t6b_fifo_flushed", 32'(bus_log.size()), 32'd0);
        check("t6b_no_strobe", 32'(n_strobe - n0), 32'd0);
        check("t6b_ready", 32'(sample_ready), 32'd1);
        push(16'h0800, ok(16'h0800));
        drain("t6c");
        expect_seq("t6c", 1, 1'b1);
        check("log_empty", 32'(bus_log.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
